// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Contents: state encoding, opcode/func values, mux-select codes, trap causes,
// ALU operation codes and the instruction legality check.
package mc_ctrl_pkg;

  // ALU op codes below need at least this many bits of aluc.
  localparam int ALUC_W_MIN = 4;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_TRAP = 3'd7
  } state_e;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // Datapath mux selects
  localparam logic [1:0] PC_SRC_INC = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;
  localparam logic [1:0] PC_SRC_A   = 2'b11;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_REG   = 2'b01;
  localparam logic [1:0] SRC_A_SHAMT = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_SEXT = 2'b01;
  localparam logic [1:0] SRC_B_ZEXT = 2'b10;
  localparam logic [1:0] SRC_B_LUI  = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_C   = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TMO     = 2'b10;

  // ALU operations; zero-extended onto the ALUC_W-wide aluc bus.
  typedef logic [ALUC_W_MIN-1:0] aluop_t;
  localparam aluop_t ALU_ADD   = 4'd0;
  localparam aluop_t ALU_SUB   = 4'd1;
  localparam aluop_t ALU_AND   = 4'd2;
  localparam aluop_t ALU_OR    = 4'd3;
  localparam aluop_t ALU_XOR   = 4'd4;
  localparam aluop_t ALU_NOR   = 4'd5;
  localparam aluop_t ALU_SLT   = 4'd6;
  localparam aluop_t ALU_SLTU  = 4'd7;
  localparam aluop_t ALU_SLL   = 4'd8;
  localparam aluop_t ALU_SRL   = 4'd9;
  localparam aluop_t ALU_SRA   = 4'd10;
  localparam aluop_t ALU_PASSB = 4'd11;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] func);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU control decode: (op, func) -> ALU op and operand selects.
// Ports: op_i/func_i instruction fields in; aluc_o, alu_src_a_o, alu_src_b_o out.
// Unknown encodings fall back to ADD on A/B; legality is checked elsewhere.
module mc_alu_decode
  import mc_ctrl_pkg::*;
#(
  parameter int ALUC_W = 4
) (
  input  logic [5:0]        op_i,
  input  logic [5:0]        func_i,
  output logic [ALUC_W-1:0] aluc_o,
  output logic [1:0]        alu_src_a_o,
  output logic [1:0]        alu_src_b_o
);

  aluop_t code;

  always_comb begin
    code        = ALU_ADD;
    alu_src_a_o = SRC_A_REG;
    alu_src_b_o = SRC_B_REG;
    case (op_i)
      OP_RTYPE: begin
        case (func_i)
          // Shifts move B (rt) by the shamt field routed onto operand A.
          FN_SLL: begin code = ALU_SLL; alu_src_a_o = SRC_A_SHAMT; end
          FN_SRL: begin code = ALU_SRL; alu_src_a_o = SRC_A_SHAMT; end
          FN_SRA: begin code = ALU_SRA; alu_src_a_o = SRC_A_SHAMT; end
          FN_SUB, FN_SUBU: code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_XOR:  code = ALU_XOR;
          FN_NOR:  code = ALU_NOR;
          FN_SLT:  code = ALU_SLT;
          FN_SLTU: code = ALU_SLTU;
          default: code = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE:   code = ALU_SUB;
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        code = ALU_ADD; alu_src_b_o = SRC_B_SEXT;
      end
      OP_SLTI:  begin code = ALU_SLT;  alu_src_b_o = SRC_B_SEXT; end
      OP_SLTIU: begin code = ALU_SLTU; alu_src_b_o = SRC_B_SEXT; end
      // Logical immediates are zero-extended.
      OP_ANDI:  begin code = ALU_AND;  alu_src_b_o = SRC_B_ZEXT; end
      OP_ORI:   begin code = ALU_OR;   alu_src_b_o = SRC_B_ZEXT; end
      OP_XORI:  begin code = ALU_XOR;  alu_src_b_o = SRC_B_ZEXT; end
      OP_LUI:   begin code = ALU_PASSB; alu_src_b_o = SRC_B_LUI; end
      default:  code = ALU_ADD;
    endcase
  end

  assign aluc_o = ALUC_W'(code);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM (IF/ID/EX/MEM/WB/TRAP) with memory handshake,
// timeout and illegal-instruction trap, and a retired-instruction counter.
// Ports: clk/rst; op_i, func_i, zero_i, mem_ready_i in; datapath enables,
// mux selects, aluc_o, trap_o/trap_cause_o, instret_o, state_out_o out.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUC_W  = 4,
  parameter int TMO_W   = 8,
  parameter int MEM_TMO = 200,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op_i,
  input  logic [5:0]        func_i,
  input  logic              zero_i,
  input  logic              mem_ready_i,
  output logic              mem_req_o,
  output logic              iord_o,
  output logic              write_mem_o,
  output logic              write_ir_o,
  output logic              write_dr_o,
  output logic              write_pc_o,
  output logic [1:0]        pc_src_o,
  output logic              write_a_o,
  output logic              write_b_o,
  output logic [1:0]        alu_src_a_o,
  output logic [1:0]        alu_src_b_o,
  output logic [ALUC_W-1:0] aluc_o,
  output logic              write_c_o,
  output logic [1:0]        reg_dst_o,
  output logic [1:0]        mem_to_reg_o,
  output logic              write_reg_o,
  output logic              trap_o,
  output logic [1:0]        trap_cause_o,
  output logic [CNT_W-1:0]  instret_o,
  output logic [2:0]        state_out_o
);

  // Trap fires when the counter already holds MEM_TMO-1 and another wait
  // cycle is about to be counted.
  localparam logic [TMO_W-1:0] TMO_LIM = (MEM_TMO == 0) ? '0 : TMO_W'(MEM_TMO - 1);

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               trap_q, trap_d;
  logic [1:0]         cause_q, cause_d;

  logic               retire;
  logic               mem_wait;
  logic               tmo_hit;
  logic               is_r, is_j, is_jal, is_jr, is_br, is_lw, is_sw, br_taken;
  logic [ALUC_W-1:0]  dec_aluc;
  logic [1:0]         dec_src_a, dec_src_b;

  mc_alu_decode #(.ALUC_W(ALUC_W)) u_alu_decode (
    .op_i        (op_i),
    .func_i      (func_i),
    .aluc_o      (dec_aluc),
    .alu_src_a_o (dec_src_a),
    .alu_src_b_o (dec_src_b)
  );

  assign is_r     = (op_i == OP_RTYPE);
  assign is_j     = (op_i == OP_J);
  assign is_jal   = (op_i == OP_JAL);
  assign is_jr    = is_r && (func_i == FN_JR);
  assign is_br    = (op_i == OP_BEQ) || (op_i == OP_BNE);
  assign is_lw    = (op_i == OP_LW);
  assign is_sw    = (op_i == OP_SW);
  assign br_taken = ((op_i == OP_BEQ) && zero_i) || ((op_i == OP_BNE) && !zero_i);

  assign mem_wait = ((state_q == ST_IF) || (state_q == ST_MEM)) && !mem_ready_i;
  assign tmo_hit  = (MEM_TMO != 0) && mem_wait && (tmo_q == TMO_LIM);

  // State and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IF;
      tmo_q     <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  // Next-state, retire and trap capture
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    trap_d  = trap_q;
    cause_d = cause_q;
    case (state_q)
      ST_IF: begin
        // mem_ready has priority over a coincident timeout.
        if (mem_ready_i) begin
          state_d = ST_ID;
        end else if (tmo_hit) begin
          state_d = ST_TRAP; trap_d = 1'b1; cause_d = CAUSE_TMO;
        end
      end
      ST_ID: begin
        if (!is_legal(op_i, func_i)) begin
          state_d = ST_TRAP; trap_d = 1'b1; cause_d = CAUSE_ILLEGAL;
        end else if (is_j || is_jal || is_jr) begin
          state_d = ST_IF; retire = 1'b1;
        end else begin
          state_d = ST_EX;
        end
      end
      ST_EX: begin
        if (is_br) begin
          state_d = ST_IF; retire = 1'b1;
        end else if (is_lw || is_sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ready_i) begin
          if (is_lw) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_IF; retire = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = ST_TRAP; trap_d = 1'b1; cause_d = CAUSE_TMO;
        end
      end
      ST_WB: begin
        state_d = ST_IF; retire = 1'b1;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IF;
    endcase

    // Wait counter restarts on every fresh entry into a memory state.
    tmo_d = tmo_q;
    if ((state_d != state_q) && ((state_d == ST_IF) || (state_d == ST_MEM))) begin
      tmo_d = '0;
    end else if (mem_wait) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    instret_d = instret_q + CNT_W'(retire);
  end

  // Output decode
  always_comb begin
    mem_req_o    = 1'b0;
    iord_o       = 1'b0;
    write_mem_o  = 1'b0;
    write_ir_o   = 1'b0;
    write_dr_o   = 1'b0;
    write_pc_o   = 1'b0;
    pc_src_o     = PC_SRC_INC;
    write_a_o    = 1'b0;
    write_b_o    = 1'b0;
    alu_src_a_o  = SRC_A_PC;
    alu_src_b_o  = SRC_B_REG;
    aluc_o       = ALUC_W'(ALU_ADD);
    write_c_o    = 1'b0;
    reg_dst_o    = RD_RT;
    mem_to_reg_o = M2R_C;
    write_reg_o  = 1'b0;
    case (state_q)
      ST_IF: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          write_ir_o = 1'b1;
          write_pc_o = 1'b1;
        end
      end
      ST_ID: begin
        write_a_o = 1'b1;
        write_b_o = 1'b1;
        if (is_j) begin
          write_pc_o = 1'b1; pc_src_o = PC_SRC_JMP;
        end else if (is_jal) begin
          write_pc_o   = 1'b1; pc_src_o = PC_SRC_JMP;
          write_reg_o  = 1'b1;
          reg_dst_o    = RD_RA;
          mem_to_reg_o = M2R_PC;
        end else if (is_jr) begin
          write_pc_o = 1'b1; pc_src_o = PC_SRC_A;
        end
      end
      ST_EX: begin
        write_c_o   = 1'b1;
        aluc_o      = dec_aluc;
        alu_src_a_o = dec_src_a;
        alu_src_b_o = dec_src_b;
        // PC+4 was already committed in IF, so only a taken branch writes PC.
        if (is_br) begin
          write_pc_o = br_taken;
          pc_src_o   = br_taken ? PC_SRC_BR : PC_SRC_INC;
        end
      end
      ST_MEM: begin
        mem_req_o   = 1'b1;
        iord_o      = 1'b1;
        write_mem_o = is_sw;
        write_dr_o  = is_lw && mem_ready_i;
      end
      ST_WB: begin
        write_reg_o  = 1'b1;
        reg_dst_o    = is_r ? RD_RD : RD_RT;
        mem_to_reg_o = is_lw ? M2R_MDR : M2R_C;
      end
      default: ;
    endcase

    // The state register sits in IF during reset; keep every enable quiet.
    if (rst) begin
      mem_req_o   = 1'b0;
      write_mem_o = 1'b0;
      write_ir_o  = 1'b0;
      write_dr_o  = 1'b0;
      write_pc_o  = 1'b0;
      write_a_o   = 1'b0;
      write_b_o   = 1'b0;
      write_c_o   = 1'b0;
      write_reg_o = 1'b0;
    end
  end

  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;
  assign state_out_o  = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: the stimulus thread drives one cycle of
// inputs and queues that cycle's hand-derived expectation; a monitor thread
// pops and compares on each falling edge.
module tb_mc_ctrl_fsm;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
                         S_WB = 3'd4, S_TRAP = 3'd7;

  // Enable vector: {mem_req, iord, write_mem, write_ir, write_dr, write_pc,
  //                 write_a, write_b, write_c, write_reg}
  localparam logic [9:0] MREQ = 10'h200, IORD = 10'h100, WMEM = 10'h080,
                         WIR = 10'h040, WDR = 10'h020, WPC = 10'h010,
                         WA = 10'h008, WB_ = 10'h004, WC = 10'h002,
                         WREG = 10'h001, ALL = 10'h3FF;
  // Select vector: {pc_src, reg_dst, mem_to_reg}
  localparam logic [5:0] M_PC = 6'b110000, M_RD = 6'b001100, M_MR = 6'b000011;
  // ALU vector: {alu_src_a, alu_src_b, aluc}
  localparam logic [7:0] M_SA = 8'hC0, M_SB = 8'h30;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] op, func;
  logic zero, mem_ready;
  logic mem_req, iord, write_mem, write_ir, write_dr, write_pc, write_a, write_b;
  logic write_c, write_reg, trap;
  logic [1:0] pc_src, alu_src_a, alu_src_b, reg_dst, mem_to_reg, trap_cause;
  logic [3:0] aluc;
  logic [31:0] instret;
  logic [2:0] state_out;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.ALUC_W(4), .TMO_W(8), .MEM_TMO(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op_i(op), .func_i(func), .zero_i(zero),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req), .iord_o(iord),
    .write_mem_o(write_mem), .write_ir_o(write_ir), .write_dr_o(write_dr),
    .write_pc_o(write_pc), .pc_src_o(pc_src), .write_a_o(write_a),
    .write_b_o(write_b), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .aluc_o(aluc), .write_c_o(write_c), .reg_dst_o(reg_dst),
    .mem_to_reg_o(mem_to_reg), .write_reg_o(write_reg), .trap_o(trap),
    .trap_cause_o(trap_cause), .instret_o(instret), .state_out_o(state_out)
  );

  logic [9:0] en_act;
  logic [5:0] sel_act;
  logic [7:0] alu_act;
  assign en_act  = {mem_req, iord, write_mem, write_ir, write_dr, write_pc,
                    write_a, write_b, write_c, write_reg};
  assign sel_act = {pc_src, reg_dst, mem_to_reg};
  assign alu_act = {alu_src_a, alu_src_b, aluc};

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [9:0]  en;
    logic [9:0]  en_m;
    logic [5:0]  sel;
    logic [5:0]  sel_m;
    logic [7:0]  alu;
    logic [7:0]  alu_m;
    logic        tr;
    logic [1:0]  cs;
    logic [31:0] ir;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] ir_e;
  logic        trap_e;
  logic [1:0]  cause_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
  endtask

  // One clock of stimulus plus its expectation; ret marks the retiring cycle.
  task automatic cyc(input string tag, input logic [2:0] s, input logic rdy,
                     input logic [9:0] en, input logic [9:0] en_m,
                     input logic [5:0] sel, input logic [5:0] sel_m,
                     input logic [7:0] alu, input logic [7:0] alu_m,
                     input logic ret);
    exp_t e;
    mem_ready = rdy;
    e.tag = tag; e.st = s; e.en = en; e.en_m = en_m;
    e.sel = sel; e.sel_m = sel_m; e.alu = alu; e.alu_m = alu_m;
    e.tr = trap_e; e.cs = cause_e; e.ir = ir_e;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (ret) ir_e = ir_e + 32'd1;
  endtask

  task automatic c_if(input string tag);
    cyc({tag, " IF"}, S_IF, 1'b1, MREQ | WIR | WPC, ALL, 6'b000000, M_PC, 8'h00, M_SA, 1'b0);
  endtask

  task automatic c_wait(input string tag);
    cyc({tag, " wait"}, S_IF, 1'b0, MREQ, ALL, 6'b0, 6'b0, 8'h0, 8'h0, 1'b0);
  endtask

  task automatic c_id(input string tag);
    cyc({tag, " ID"}, S_ID, 1'b1, WA | WB_, ALL, 6'b0, 6'b0, 8'h0, 8'h0, 1'b0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.tag, " state"}, 32'(state_out), 32'(e.st));
        chk({e.tag, " enables"}, 32'(en_act & e.en_m), 32'(e.en & e.en_m));
        if (e.sel_m != 6'b0) chk({e.tag, " selects"}, 32'(sel_act & e.sel_m), 32'(e.sel & e.sel_m));
        if (e.alu_m != 8'b0) chk({e.tag, " alu"}, 32'(alu_act & e.alu_m), 32'(e.alu & e.alu_m));
        chk({e.tag, " trap"}, 32'({trap, trap_cause}), 32'({e.tr, e.cs}));
        chk({e.tag, " instret"}, instret, e.ir);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Stimulus
  initial begin
    rst = 1'b1; op = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    ir_e = 32'd0; trap_e = 1'b0; cause_e = 2'b00;
    @(posedge clk);
    #1;
    // mem_ready high during reset must not leak any enable
    cyc("reset0", S_IF, 1'b1, 10'h0, ALL, 6'b0, 6'b0, 8'h0, 8'h0, 1'b0);
    cyc("reset1", S_IF, 1'b1, 10'h0, ALL, 6'b0, 6'b0, 8'h0, 8'h0, 1'b0);
    rst = 1'b0;

    // ADD: 4 cycles
    op = 6'b000000; func = 6'b100000;
    c_if("add"); c_id("add");
    cyc("add EX", S_EX, 1'b1, WC, ALL, 6'b0, 6'b0, 8'h40, 8'hFF, 1'b0);
    cyc("add WB", S_WB, 1'b1, WREG, ALL, 6'b000100, M_RD | M_MR, 8'h0, 8'h0, 1'b1);

    // LW with three MEM wait cycles (also the timeout boundary in MEM): 8 cycles
    op = 6'b100011;
    c_if("lw"); c_id("lw");
    cyc("lw EX", S_EX, 1'b1, WC, ALL, 6'b0, 6'b0, 8'h50, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("lw MEM wait", S_MEM, 1'b0, MREQ | IORD, ALL, 6'b0, 6'b0, 8'h0, 8'h0, 1'b0);
    cyc("lw MEM rdy", S_MEM, 1'b1, MREQ | IORD | WDR, ALL, 6'b0, 6'b0, 8'h0, 8'h0, 1'b0);
    cyc("lw WB", S_WB, 1'b1, WREG, ALL, 6'b000001, M_RD | M_MR, 8'h0, 8'h0, 1'b1);

    // BEQ taken, BNE not taken: 3 cycles each
    zero = 1'b1;
    op = 6'b000100;
    c_if("beq"); c_id("beq");
    cyc("beq EX", S_EX, 1'b1, WC, ALL & ~WPC, 6'b010000, M_PC, 8'h41, 8'hFF, 1'b1);
    op = 6'b000101;
    c_if("bne"); c_id("bne");
    cyc("bne EX", S_EX, 1'b1, WC, ALL & ~WPC, 6'b000000, M_PC, 8'h41, 8'hFF, 1'b1);
    zero = 1'b0;

    // JAL, JR: 2 cycles each
    op = 6'b000011;
    c_if("jal");
    cyc("jal ID", S_ID, 1'b1, WA | WB_ | WPC | WREG, ALL, 6'b101010, 6'b111111, 8'h0, 8'h0, 1'b1);
    op = 6'b000000; func = 6'b001000;
    c_if("jr");
    cyc("jr ID", S_ID, 1'b1, WA | WB_ | WPC, ALL, 6'b110000, M_PC, 8'h0, 8'h0, 1'b1);

    // J with mem_ready arriving on the 4th IF cycle: no trap
    op = 6'b000010;
    for (int i = 0; i < 3; i++) c_wait("j");
    c_if("j");
    cyc("j ID", S_ID, 1'b1, WA | WB_ | WPC, ALL, 6'b100000, M_PC, 8'h0, 8'h0, 1'b1);

    // SW: 4 cycles
    op = 6'b101011;
    c_if("sw"); c_id("sw");
    cyc("sw EX", S_EX, 1'b1, WC, ALL, 6'b0, 6'b0, 8'h50, 8'hFF, 1'b0);
    cyc("sw MEM", S_MEM, 1'b1, MREQ | IORD | WMEM, ALL, 6'b0, 6'b0, 8'h0, 8'h0, 1'b1);

    // SLL uses shamt on A; LUI uses imm<<16 on B
    op = 6'b000000; func = 6'b000000;
    c_if("sll"); c_id("sll");
    cyc("sll EX", S_EX, 1'b1, WC, ALL, 6'b0, 6'b0, 8'h80, M_SA | M_SB, 1'b0);
    cyc("sll WB", S_WB, 1'b1, WREG, ALL, 6'b000100, M_RD | M_MR, 8'h0, 8'h0, 1'b1);
    op = 6'b001111;
    c_if("lui"); c_id("lui");
    cyc("lui EX", S_EX, 1'b1, WC, ALL, 6'b0, 6'b0, 8'h30, M_SB, 1'b0);
    cyc("lui WB", S_WB, 1'b1, WREG, ALL, 6'b000000, M_RD | M_MR, 8'h0, 8'h0, 1'b1);

    // IF timeout: four wait cycles then TRAP with cause 10
    op = 6'b000000; func = 6'b100000;
    for (int i = 0; i < 4; i++) c_wait("tmo");
    trap_e = 1'b1; cause_e = 2'b10;
    cyc("tmo TRAP0", S_TRAP, 1'b0, 10'h0, ALL, 6'b0, 6'b0, 8'h0, 8'h0, 1'b0);
    cyc("tmo TRAP1", S_TRAP, 1'b1, 10'h0, ALL, 6'b0, 6'b0, 8'h0, 8'h0, 1'b0);
    rst = 1'b1; trap_e = 1'b0; cause_e = 2'b00; ir_e = 32'd0;
    cyc("tmo reset", S_IF, 1'b1, 10'h0, ALL, 6'b0, 6'b0, 8'h0, 8'h0, 1'b0);
    rst = 1'b0;

    // Illegal opcode: TRAP with cause 01, sticky until reset
    op = 6'b111111;
    c_if("ill"); c_id("ill");
    trap_e = 1'b1; cause_e = 2'b01;
    cyc("ill TRAP0", S_TRAP, 1'b1, 10'h0, ALL, 6'b0, 6'b0, 8'h0, 8'h0, 1'b0);
    cyc("ill TRAP1", S_TRAP, 1'b1, 10'h0, ALL, 6'b0, 6'b0, 8'h0, 8'h0, 1'b0);
    rst = 1'b1; trap_e = 1'b0; cause_e = 2'b00; ir_e = 32'd0;
    cyc("ill reset", S_IF, 1'b1, 10'h0, ALL, 6'b0, 6'b0, 8'h0, 8'h0, 1'b0);
    rst = 1'b0;
    op = 6'b000000;
    c_wait("post");

    @(negedge clk);
    #1;
    chk("queue drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
